// File: rtl/exu_wbck_arb.sv
// Write-back arbiter: picks the buffered long-pipe result (older) or the ALU result and registers it
// onto the regfile write port. Define E203_WBCK_FWD_EN to forward output-stage data to issue.

`ifndef E203_XLEN
`define E203_XLEN 32
`endif
`ifndef E203_RFIDX_WIDTH
`define E203_RFIDX_WIDTH 5
`endif

module exu_wbck_arb #(
    parameter int unsigned LBUF_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          alu_wbck_i_valid,
    output logic                          alu_wbck_i_ready,
    input  logic [`E203_RFIDX_WIDTH-1:0]  alu_wbck_i_rdidx,
    input  logic [`E203_XLEN-1:0]         alu_wbck_i_wdat,

    input  logic                          longp_wbck_i_valid,
    output logic                          longp_wbck_i_ready,
    input  logic [`E203_RFIDX_WIDTH-1:0]  longp_wbck_i_rdidx,
    input  logic [`E203_XLEN-1:0]         longp_wbck_i_wdat,

    output logic                          wbck_dest_wen,
    output logic [`E203_RFIDX_WIDTH-1:0]  wbck_dest_idx,
    output logic [`E203_XLEN-1:0]         wbck_dest_dat,

    input  logic [`E203_RFIDX_WIDTH-1:0]  read_src1_idx,
    input  logic [`E203_RFIDX_WIDTH-1:0]  read_src2_idx,
    output logic                          src1_pend,
    output logic                          src2_pend,
    output logic                          fwd_src1_vld,
    output logic                          fwd_src2_vld,
    output logic [`E203_XLEN-1:0]         fwd_dat
);

    localparam int unsigned IW    = `E203_RFIDX_WIDTH;
    localparam int unsigned XW    = `E203_XLEN;
    localparam int unsigned PTR_W = $clog2(LBUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [IW-1:0]    buf_idx [LBUF_DEPTH];
    logic [XW-1:0]    buf_dat [LBUF_DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0] cnt;

    logic fifo_empty, fifo_full, push, pop, alu_hs;
    logic [LBUF_DEPTH-1:0] ent_vld;

    assign fifo_empty         = (cnt == '0);
    assign fifo_full          = (cnt == CNT_W'(LBUF_DEPTH));
    assign longp_wbck_i_ready = !fifo_full;
    assign alu_wbck_i_ready   = fifo_empty;
    assign push               = longp_wbck_i_valid && longp_wbck_i_ready;
    assign pop                = !fifo_empty;
    assign alu_hs             = alu_wbck_i_valid && alu_wbck_i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      cnt <= cnt + 1'b1;
            else if (pop && !push) cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_idx[wptr] <= longp_wbck_i_rdidx;
            buf_dat[wptr] <= longp_wbck_i_wdat;
        end
    end

    // Output stage: FIFO head has priority; idx/dat hold when no winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbck_dest_wen <= 1'b0;
            wbck_dest_idx <= '0;
            wbck_dest_dat <= '0;
        end else begin
            wbck_dest_wen <= pop || alu_hs;
            if (pop) begin
                wbck_dest_idx <= buf_idx[rptr];
                wbck_dest_dat <= buf_dat[rptr];
            end else if (alu_hs) begin
                wbck_dest_idx <= alu_wbck_i_rdidx;
                wbck_dest_dat <= alu_wbck_i_wdat;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        ent_vld = '0;
        for (int unsigned i = 0; i < LBUF_DEPTH; i++) begin
            ent_vld[i] = ({1'b0, PTR_W'(i) - rptr} < cnt);
        end
    end

    logic fifo_hit1, fifo_hit2, out_hit1, out_hit2;

    always_comb begin
        fifo_hit1 = 1'b0;
        fifo_hit2 = 1'b0;
        for (int unsigned i = 0; i < LBUF_DEPTH; i++) begin
            if (ent_vld[i] && (buf_idx[i] == read_src1_idx)) fifo_hit1 = 1'b1;
            if (ent_vld[i] && (buf_idx[i] == read_src2_idx)) fifo_hit2 = 1'b1;
        end
        fifo_hit1 = fifo_hit1 && (read_src1_idx != '0);
        fifo_hit2 = fifo_hit2 && (read_src2_idx != '0);
    end

    assign out_hit1 = wbck_dest_wen && (read_src1_idx != '0) && (wbck_dest_idx == read_src1_idx);
    assign out_hit2 = wbck_dest_wen && (read_src2_idx != '0) && (wbck_dest_idx == read_src2_idx);

`ifdef E203_WBCK_FWD_EN
    // A younger write still in the FIFO makes the staged value stale.
    assign src1_pend    = fifo_hit1;
    assign src2_pend    = fifo_hit2;
    assign fwd_src1_vld = out_hit1 && !fifo_hit1;
    assign fwd_src2_vld = out_hit2 && !fifo_hit2;
    assign fwd_dat      = wbck_dest_dat;
`else
    assign src1_pend    = fifo_hit1 || out_hit1;
    assign src2_pend    = fifo_hit2 || out_hit2;
    assign fwd_src1_vld = 1'b0;
    assign fwd_src2_vld = 1'b0;
    assign fwd_dat      = '0;
`endif

endmodule
